// File: rtl/tea_byte_framer.sv
// Byte-serial command framer around the TEA core: assembles key and
// plaintext from an RX byte stream, launches the core, streams ciphertext out.
module tea_byte_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_KEY        = 8'h4B,
    parameter logic [7:0]  CMD_ENC        = 8'h45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] key1,
    output logic [31:0] key2,
    output logic [31:0] key3,
    output logic [31:0] key4,
    output logic [31:0] v1,
    output logic [31:0] v2,
    output logic        core_start,
    input  logic        core_done,
    input  logic [31:0] v1_enc,
    input  logic [31:0] v2_enc,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        key_loaded,
    output logic        busy,
    output logic        err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        DATA,
        START,
        WAIT,
        SEND
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [4:0]     cnt;
    logic [TW-1:0]  idle;
    logic [127:0]   shadow;
    logic [127:0]   key;
    logic [63:0]    vreg;
    logic [63:0]    txsh;
    logic           err_nx;
    logic           cnt_clr;
    logic           key_shift;
    logic           key_commit;
    logic           v_shift;
    logic           cap;
    logic           tx_shift;
    logic           in_frame;
    logic           timeout;

    assign in_frame = (state == KEY) || (state == DATA);
    assign timeout  = in_frame && !rx_valid && (idle == IDLE_LAST);

    always_comb begin
        state_nx   = state;
        err_nx     = 1'b0;
        cnt_clr    = 1'b0;
        key_shift  = 1'b0;
        key_commit = 1'b0;
        v_shift    = 1'b0;
        cap        = 1'b0;
        tx_shift   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_KEY) begin
                        state_nx = KEY;
                        cnt_clr  = 1'b1;
                    end else if (rx_data == CMD_ENC && key_loaded) begin
                        state_nx = DATA;
                        cnt_clr  = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            KEY: begin
                if (rx_valid) begin
                    key_shift = 1'b1;
                    if (cnt == 5'd15) begin
                        key_commit = 1'b1;
                        state_nx   = IDLE;
                    end
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    v_shift = 1'b1;
                    if (cnt == 5'd7) state_nx = START;
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            START: begin
                err_nx   = rx_valid;
                state_nx = WAIT;
            end
            WAIT: begin
                err_nx = rx_valid;
                if (core_done) begin
                    cap      = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                err_nx = rx_valid;
                if (tx_ready) begin
                    tx_shift = 1'b1;
                    if (cnt == 5'd7) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idle       <= '0;
            shadow     <= '0;
            key        <= '0;
            vreg       <= '0;
            txsh       <= '0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= err_nx;
            if (cnt_clr) cnt <= '0;
            else if (key_shift || v_shift || tx_shift) cnt <= cnt + 5'd1;
            // Idle counter only runs while a frame is being collected
            if (!in_frame || rx_valid || timeout) idle <= '0;
            else idle <= idle + 1'b1;
            if (key_shift) shadow <= {shadow[119:0], rx_data};
            if (key_commit) begin
                key        <= {shadow[119:0], rx_data};
                key_loaded <= 1'b1;
            end
            if (v_shift) vreg <= {vreg[55:0], rx_data};
            if (cap) txsh <= {v1_enc, v2_enc};
            else if (tx_shift) txsh <= {txsh[55:0], 8'h00};
        end
    end

    assign key1       = key[127:96];
    assign key2       = key[95:64];
    assign key3       = key[63:32];
    assign key4       = key[31:0];
    assign v1         = vreg[63:32];
    assign v2         = vreg[31:0];
    assign core_start = (state == START);
    assign tx_valid   = (state == SEND);
    assign tx_data    = txsh[63:56];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_tea_byte_framer.sv
// Bench for tea_byte_framer: table of key/plaintext/ciphertext vectors with a
// tx scoreboard, plus hand-written reset, error and timeout sequences.
module tb_tea_byte_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] key1, key2, key3, key4, v1, v2;
    logic        core_start;
    logic        core_done = 1'b0;
    logic [31:0] v1_enc = '0;
    logic [31:0] v2_enc = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        key_loaded, busy, err;

    always #5 clk = ~clk;

    tea_byte_framer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .v1(v1), .v2(v2),
        .core_start(core_start), .core_done(core_done),
        .v1_enc(v1_enc), .v2_enc(v2_enc),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .key_loaded(key_loaded), .busy(busy), .err(err)
    );

    typedef struct {
        logic [127:0] key;
        logic [63:0]  pt;
        logic [63:0]  ct;
        bit           slow;
        bit           ovr;
    } vec_t;

    vec_t       tbl[3];
    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         start_seen = 0;
    int         cd = 0;
    int         rc = 0;
    bit         ready_mode = 1'b0;
    bit         stall = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        send(8'h4B);
        for (int i = 0; i < 16; i++) send(k[127-8*i -: 8]);
    endtask

    // Core model and downstream ready pattern
    initial begin
        forever begin
            tick();
            core_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) core_done = 1'b1;
            end
            tx_ready = ready_mode ? (rc % 3 == 0) : 1'b1;
            rc++;
        end
    end

    always @(negedge clk) begin
        if (err) err_seen++;
        if (core_start) begin
            start_seen++;
            cd = 3;
        end
        if (stall) chk("tx_hold", {tx_valid, tx_data}, {1'b1, held});
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_extra: got byte %0h expected none", tx_data);
            end else begin
                chk("tx_byte", tx_data, exp_q.pop_front());
            end
        end
        stall = tx_valid && !tx_ready;
        held  = tx_data;
    end

    initial begin
        int n;
        int s0;
        int e0;
        tbl[0] = '{128'h0, 64'h0, 64'h41EA3A0A_94BAA940, 1'b0, 1'b0};
        tbl[1] = '{128'h00010203_04050607_08090A0B_0C0D0E0F,
                   64'h4B450123_456789AB, 64'hDEADBEEF_0BADF00D, 1'b1, 1'b0};
        tbl[2] = '{{128{1'b1}}, 64'hFEDCBA98_76543210,
                   64'h01234567_89ABCDEF, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_keys", {key1, key2, key3, key4}, 128'h0);
        chk("rst_v", {v1, v2}, 128'h0);
        chk("rst_flags", {key_loaded, busy, core_start, tx_valid, err, tx_data},
            128'h0);
        tick();
        reset = 1'b1;
        tick();

        send(8'h00);
        @(negedge clk);
        chk("err_badcmd", {err, busy}, 2'b10);
        tick();

        send(8'h45);
        @(negedge clk);
        chk("err_nokey", {err, busy}, 2'b10);
        tick();
        repeat (3) tick();
        chk("nokey_idle", {start_seen[7:0], busy, key_loaded}, 10'h0);

        for (int v = 0; v < 3; v++) begin
            load_key(tbl[v].key);
            @(negedge clk);
            chk("key_val", {key1, key2, key3, key4}, tbl[v].key);
            chk("key_flags", {key_loaded, busy}, 2'b10);
            tick();
            ready_mode = tbl[v].slow;
            v1_enc = tbl[v].ct[63:32];
            v2_enc = tbl[v].ct[31:0];
            for (int i = 0; i < 8; i++) exp_q.push_back(tbl[v].ct[63-8*i -: 8]);
            s0 = start_seen;
            send(8'h45);
            for (int i = 0; i < 8; i++) send(tbl[v].pt[63-8*i -: 8]);
            @(negedge clk);
            chk("core_start", {core_start, busy}, 2'b11);
            chk("plaintext", {v1, v2}, tbl[v].pt);
            if (tbl[v].ovr) begin
                tick();
                send(8'h4B);
                @(negedge clk);
                chk("err_overrun", {err, busy}, 2'b11);
            end
            n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("tx_drain", exp_q.size(), 0);
            exp_q.delete();
            @(negedge clk);
            chk("tx_done", {tx_valid, busy}, 2'b00);
            chk("start_once", start_seen - s0, 1);
            tick();
        end

        ready_mode = 1'b0;
        e0 = err_seen;
        send(8'h4B);
        for (int i = 0; i < 5; i++) send(8'h45);
        n = 0;
        while (err_seen == e0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("err_timeout", err_seen - e0, 1);
        chk("timeout_key", {key1, key2, key3, key4}, tbl[2].key);
        chk("timeout_flags", {key_loaded, busy}, 2'b10);
        tick();

        load_key(128'h00010203_04050607_08090A0B_0C0D0E0F);
        send(8'h45);
        for (int i = 0; i < 3; i++) send(8'h11 * i);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_keys", {key1, key2, key3, key4}, 128'h0);
        chk("mid_rst_v", {v1, v2}, 128'h0);
        chk("mid_rst_flags",
            {key_loaded, busy, core_start, tx_valid, err, tx_data}, 128'h0);
        tick();
        send(8'h45);
        @(negedge clk);
        chk("mid_rst_idle", {err, busy}, 2'b10);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
